parity_count_arbiter: RTL and testbench
=======================================

Name: parity_count_arbiter

Overview:
Shares a single odd/even step counter between two requesters. Each requester asks for a burst of N count values in even (0,2,4,…) or odd (1,3,5,…) mode, and the block grants them round-robin. It sequences the counter (load seed, step by 2, stop) and reports completion. It sits between client FSMs and the parity counter datapath.

Parameters:
WIDTH, 2, counter width; values wrap modulo 2^WIDTH
LEN_W, 4, width of each burst-length field

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req  in  2  request per requester; must be held high until done
mode  in  2  per requester: 0 = even sequence, 1 = odd sequence
len0  in  LEN_W  burst length for requester 0
len1  in  LEN_W  burst length for requester 1
gnt  out  2  one-hot grant, high for the whole burst
count  out  WIDTH  current counter value
count_valid  out  1  count carries a burst value this cycle
done  out  2  one-cycle pulse with the last value of a burst
busy  out  1  high while the state is RUN

Behaviour:
- Reset (rst=0, async): state=IDLE, gnt=0, count=0, count_valid=0, done=0, busy=0, rr pointer=0 (requester 0 favoured).
- States: IDLE, RUN.
- IDLE arbitration:
  - If any req is high, pick a winner. A single request wins outright. If both are high, the winner is the requester named by the rr pointer.
  - Latch the winner's mode and len into internal registers and go to RUN.
- First RUN cycle (the cycle after the request is seen in IDLE):
  - gnt = onehot(winner), busy=1, count_valid=1.
  - count = seed: 0 for even, 1 for odd.
  - remaining = len-1. len=0 is treated as 1.
- Each following RUN cycle: count = count+2 mod 2^WIDTH, remaining decrements.
  - Example, WIDTH=2 even: 0,2,0,2. WIDTH=3 odd: 1,3,5,7,1.
- Last value (remaining==0):
  - done[winner]=1 in the same cycle as the last value.
  - Next cycle: state=IDLE, gnt=0, count_valid=0, busy=0, rr pointer = the other requester.
  - So there is exactly one bubble cycle between bursts.
- A burst of len values occupies exactly len cycles with count_valid=1.
- mode and len are sampled only at grant; later changes are ignored until the next grant.
- Abort: if req[winner] falls while in RUN, the next cycle goes to IDLE with gnt=0 and count_valid=0. No done pulse is issued, and the rr pointer still advances.
- The losing requester's req has no effect during RUN.
- In IDLE, count holds its last value; count_valid is the only qualifier.
- Reset asserted mid-burst: all outputs return immediately to their reset values; no done pulse.

Optional Feature:
Macro PCA_HOLD_EN.
- Defined: adds input port hold (1 bit). While hold=1 in RUN, count and remaining freeze and count_valid=0; gnt and busy stay high. A done pulse cannot occur while hold=1. Abort still takes priority over hold.
- Undefined: no hold port; a burst runs uninterrupted.

Decomposition:
- Package parity_count_pkg holds:
  - state enum (IDLE, RUN)
  - MODE_EVEN=0, MODE_ODD=1
  - seed constants
- Sub-module parity_step_counter provides the WIDTH-bit counter: load, load_odd, en; count steps by 2 with wrap.
- The arbiter FSM, rr pointer and remaining counter stay in the top module.

Test Plan:
1. Reset: rst=0 with req=11 → gnt=00, count=0, count_valid=0, done=00, busy=0. Release rst; requester 0 is granted first.
2. WIDTH=2, req=01, mode[0]=0, len0=3 → one cycle later gnt=01 and count=0,2,0 with valid. done[0] is high on the 3rd value; next cycle gnt=00, busy=0.
3. WIDTH=3, req=10, mode[1]=1, len1=5 → count=1,3,5,7,1 and done[1] on value 1.
4. Both req held, len0=len1=2, mode=10 → 0,2, one bubble, then 1,3, one bubble, then 0,2 (round-robin alternation).
5. req0, len0=8: drop req[0] after 3 values → count_valid=0 next cycle, no done. req1 pending is then granted after one IDLE cycle. Also cover len0=0 → a single value with done.
6. Assert rst mid-burst (after 2 values) → outputs reset immediately. After release, arbitration restarts favouring requester 0. With PCA_HOLD_EN, hold=1 for 3 cycles mid-burst → count frozen, count_valid=0, and the total number of valid values is still len.

Source files
------------

// File: rtl/parity_count_pkg.sv
// Shared types and constants for the parity count arbiter and its step counter.
package parity_count_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  // A burst starts at 0 (even) or 1 (odd) and then steps by 2.
  localparam logic SEED_EVEN = 1'b0;
  localparam logic SEED_ODD  = 1'b1;

endpackage

// File: rtl/parity_count_arbiter_if.sv
// Request/grant bus between two client FSMs and the parity count arbiter.
// Optional hold input is present only when PCA_HOLD_EN is defined.
interface parity_count_arbiter_if #(
  parameter int WIDTH = 2,
  parameter int LEN_W = 4
);
  // Handshake: req[i] is a level request that the client holds high until it
  // sees done[i] or withdraws it (abort); gnt[i] stays high for the whole burst;
  // count is meaningful only in cycles where count_valid is high.
  logic [1:0]       req;
  logic [1:0]       mode;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
`ifdef PCA_HOLD_EN
  logic             hold;
`endif
  logic [1:0]       gnt;
  logic [WIDTH-1:0] count;
  logic             count_valid;
  logic [1:0]       done;
  logic             busy;

`ifdef PCA_HOLD_EN
  modport master (output req, mode, len0, len1, hold,
                  input  gnt, count, count_valid, done, busy);
  modport slave  (input  req, mode, len0, len1, hold,
                  output gnt, count, count_valid, done, busy);
`else
  modport master (output req, mode, len0, len1,
                  input  gnt, count, count_valid, done, busy);
  modport slave  (input  req, mode, len0, len1,
                  output gnt, count, count_valid, done, busy);
`endif

endinterface

// File: rtl/parity_step_counter.sv
// WIDTH-bit counter that loads an even/odd seed and then steps by 2 with wrap.
module parity_step_counter
  import parity_count_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             load_odd,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= {{(WIDTH-1){1'b0}}, (load_odd ? SEED_ODD : SEED_EVEN)};
    end else if (en) begin
      count <= count + STEP;
    end
  end

endmodule

// File: rtl/parity_count_arbiter.sv
// Round-robin arbiter sharing one even/odd step counter between two requesters.
// Define PCA_HOLD_EN to add the hold input that pauses a running burst.
module parity_count_arbiter
  import parity_count_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  parity_count_arbiter_if.slave  bus,
  output logic [0:0]             dbg_state
);

  localparam logic [0:0]       ST_IDLE = IDLE;
  localparam logic [0:0]       ST_RUN  = RUN;
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  logic [0:0]       state;
  logic             winner;
  logic             rr;
  logic [LEN_W-1:0] rem;

  logic             pick;
  logic [LEN_W-1:0] pick_len;
  logic             hold_w;
  logic             run;
  logic             abort;
  logic             step_ok;
  logic             last;
  logic             cnt_load;
  logic             cnt_en;
  logic [1:0]       onehot;

`ifdef PCA_HOLD_EN
  assign hold_w = bus.hold;
`else
  assign hold_w = 1'b0;
`endif

  // A lone request wins outright; a tie goes to the rr pointer.
  always_comb begin
    pick = rr;
    if (bus.req == 2'b01) pick = 1'b0;
    if (bus.req == 2'b10) pick = 1'b1;
  end

  assign pick_len = pick ? bus.len1 : bus.len0;
  assign run      = (state == ST_RUN);
  assign abort    = run && !bus.req[winner];
  // Abort beats hold, and hold blocks both stepping and the done pulse.
  assign step_ok  = run && !abort && !hold_w;
  assign last     = (rem == '0);
  assign cnt_load = (state == ST_IDLE) && (|bus.req);
  assign cnt_en   = step_ok && !last;
  assign onehot   = winner ? 2'b10 : 2'b01;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      winner <= 1'b0;
      rr     <= 1'b0;
      rem    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            winner <= pick;
            // A zero length is served as a single value.
            rem    <= (pick_len == '0) ? '0 : pick_len - ONE;
            state  <= ST_RUN;
          end
        end
        default: begin
          if (abort || (step_ok && last)) begin
            state <= ST_IDLE;
            rr    <= ~winner;
          end else if (step_ok) begin
            rem <= rem - ONE;
          end
        end
      endcase
    end
  end

  parity_step_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_odd (bus.mode[pick] == MODE_ODD),
    .en       (cnt_en),
    .count    (bus.count)
  );

  assign bus.gnt         = run ? onehot : 2'b00;
  assign bus.busy        = run;
  assign bus.count_valid = run && !hold_w;
  assign bus.done        = (step_ok && last) ? onehot : 2'b00;
  assign dbg_state       = state;

endmodule

// File: tb/tb_parity_count_arbiter.sv
// Directed bench driving a WIDTH=2 and a WIDTH=3 arbiter with the same stimulus.
module tb_parity_count_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] mode;
  logic [3:0] len0;
  logic [3:0] len1;
  logic       hold;
  logic [0:0] st2;
  logic [0:0] st3;

  int total;
  int passed;

  parity_count_arbiter_if #(.WIDTH(2), .LEN_W(4)) if2 ();
  parity_count_arbiter_if #(.WIDTH(3), .LEN_W(4)) if3 ();

  assign if2.req  = req;
  assign if2.mode = mode;
  assign if2.len0 = len0;
  assign if2.len1 = len1;
  assign if3.req  = req;
  assign if3.mode = mode;
  assign if3.len0 = len0;
  assign if3.len1 = len1;
`ifdef PCA_HOLD_EN
  assign if2.hold = hold;
  assign if3.hold = hold;
`endif

  parity_count_arbiter #(.WIDTH(2), .LEN_W(4)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (if2),
    .dbg_state (st2)
  );

  parity_count_arbiter #(.WIDTH(3), .LEN_W(4)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .bus       (if3),
    .dbg_state (st3)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected count is given unbounded; each instance wraps it to its own width.
  task automatic check(input string tag, input logic [1:0] e_gnt, input int e_cnt,
                       input logic e_cv, input logic [1:0] e_done, input logic e_busy);
    logic [1:0] c2;
    logic [2:0] c3;
    c2 = e_cnt[1:0];
    c3 = e_cnt[2:0];
    cmp({tag, ".gnt2"},   8'(if2.gnt),         8'(e_gnt));
    cmp({tag, ".gnt3"},   8'(if3.gnt),         8'(e_gnt));
    cmp({tag, ".cnt2"},   8'(if2.count),       8'(c2));
    cmp({tag, ".cnt3"},   8'(if3.count),       8'(c3));
    cmp({tag, ".cv2"},    8'(if2.count_valid), 8'(e_cv));
    cmp({tag, ".cv3"},    8'(if3.count_valid), 8'(e_cv));
    cmp({tag, ".done2"},  8'(if2.done),        8'(e_done));
    cmp({tag, ".done3"},  8'(if3.done),        8'(e_done));
    cmp({tag, ".busy2"},  8'(if2.busy),        8'(e_busy));
    cmp({tag, ".state3"}, 8'(st3),             8'(e_busy));
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b0;
    req    = 2'b11;
    mode   = 2'b00;
    len0   = 4'd1;
    len1   = 4'd1;
    hold   = 1'b0;

    // 1: reset with both requests pending, then requester 0 first
    #3;
    check("rst", 2'b00, 0, 1'b0, 2'b00, 1'b0);
    tick();
    check("rst_edge", 2'b00, 0, 1'b0, 2'b00, 1'b0);
    rst = 1'b1;
    tick();
    check("t1_first", 2'b01, 0, 1'b1, 2'b01, 1'b1);
    tick();
    check("t1_bubble", 2'b00, 0, 1'b0, 2'b00, 1'b0);
    tick();
    check("t1_rr", 2'b10, 0, 1'b1, 2'b10, 1'b1);
    req = 2'b00;
    tick();
    check("t1_idle", 2'b00, 0, 1'b0, 2'b00, 1'b0);

    // 2: even burst of 3 from requester 0
    req = 2'b01; mode = 2'b00; len0 = 4'd3;
    tick(); check("t2_v0", 2'b01, 0, 1'b1, 2'b00, 1'b1);
    tick(); check("t2_v1", 2'b01, 2, 1'b1, 2'b00, 1'b1);
    tick(); check("t2_v2", 2'b01, 4, 1'b1, 2'b01, 1'b1);
    req = 2'b00;
    tick(); check("t2_idle", 2'b00, 4, 1'b0, 2'b00, 1'b0);

    // 3: odd burst of 5 from requester 1
    req = 2'b10; mode = 2'b10; len1 = 4'd5;
    tick(); check("t3_v0", 2'b10, 1, 1'b1, 2'b00, 1'b1);
    tick(); check("t3_v1", 2'b10, 3, 1'b1, 2'b00, 1'b1);
    tick(); check("t3_v2", 2'b10, 5, 1'b1, 2'b00, 1'b1);
    tick(); check("t3_v3", 2'b10, 7, 1'b1, 2'b00, 1'b1);
    tick(); check("t3_v4", 2'b10, 9, 1'b1, 2'b10, 1'b1);
    req = 2'b00;
    tick(); check("t3_idle", 2'b00, 9, 1'b0, 2'b00, 1'b0);

    // 4: both requesting, alternating with one bubble between bursts
    req = 2'b11; mode = 2'b10; len0 = 4'd2; len1 = 4'd2;
    tick(); check("t4_a0", 2'b01, 0, 1'b1, 2'b00, 1'b1);
    tick(); check("t4_a1", 2'b01, 2, 1'b1, 2'b01, 1'b1);
    tick(); check("t4_gap1", 2'b00, 2, 1'b0, 2'b00, 1'b0);
    tick(); check("t4_b0", 2'b10, 1, 1'b1, 2'b00, 1'b1);
    tick(); check("t4_b1", 2'b10, 3, 1'b1, 2'b10, 1'b1);
    tick(); check("t4_gap2", 2'b00, 3, 1'b0, 2'b00, 1'b0);
    tick(); check("t4_c0", 2'b01, 0, 1'b1, 2'b00, 1'b1);
    tick(); check("t4_c1", 2'b01, 2, 1'b1, 2'b01, 1'b1);
    req = 2'b00;
    tick(); check("t4_idle", 2'b00, 2, 1'b0, 2'b00, 1'b0);

    // 5: abort after 3 values; pending requester 1 is served next
    req = 2'b01; mode = 2'b00; len0 = 4'd8; len1 = 4'd1;
    tick(); check("t5_v0", 2'b01, 0, 1'b1, 2'b00, 1'b1);
    req = 2'b11; mode = 2'b11; len0 = 4'd2;
    tick(); check("t5_v1", 2'b01, 2, 1'b1, 2'b00, 1'b1);
    tick(); check("t5_v2", 2'b01, 4, 1'b1, 2'b00, 1'b1);
    req = 2'b10;
    tick(); check("t5_abort", 2'b00, 4, 1'b0, 2'b00, 1'b0);
    tick(); check("t5_r1", 2'b10, 1, 1'b1, 2'b10, 1'b1);
    req = 2'b00;
    tick(); check("t5_idle", 2'b00, 1, 1'b0, 2'b00, 1'b0);

    // 5b: zero length yields exactly one value with done
    req = 2'b01; mode = 2'b00; len0 = 4'd0;
    tick(); check("t5_len0", 2'b01, 0, 1'b1, 2'b01, 1'b1);
    req = 2'b00;
    tick(); check("t5_len0_idle", 2'b00, 0, 1'b0, 2'b00, 1'b0);

    // 6: reset mid-burst, then arbitration favours requester 0 again
    req = 2'b01; mode = 2'b00; len0 = 4'd5;
    tick(); check("t6_v0", 2'b01, 0, 1'b1, 2'b00, 1'b1);
    tick(); check("t6_v1", 2'b01, 2, 1'b1, 2'b00, 1'b1);
    rst = 1'b0;
    #1;
    check("t6_async", 2'b00, 0, 1'b0, 2'b00, 1'b0);
    req = 2'b11; len0 = 4'd1; len1 = 4'd1;
    tick(); check("t6_in_rst", 2'b00, 0, 1'b0, 2'b00, 1'b0);
    rst = 1'b1;
    tick(); check("t6_restart", 2'b01, 0, 1'b1, 2'b01, 1'b1);
    req = 2'b00;
    tick(); check("t6_idle", 2'b00, 0, 1'b0, 2'b00, 1'b0);

`ifdef PCA_HOLD_EN
    // hold for 3 cycles mid-burst: value frozen, still len valid values
    req = 2'b01; mode = 2'b01; len0 = 4'd3;
    tick(); check("hd_v0", 2'b01, 1, 1'b1, 2'b00, 1'b1);
    hold = 1'b1;
    #1; check("hd_h0", 2'b01, 1, 1'b0, 2'b00, 1'b1);
    tick(); check("hd_h1", 2'b01, 1, 1'b0, 2'b00, 1'b1);
    tick(); check("hd_h2", 2'b01, 1, 1'b0, 2'b00, 1'b1);
    hold = 1'b0;
    #1; check("hd_resume", 2'b01, 1, 1'b1, 2'b00, 1'b1);
    tick(); check("hd_v1", 2'b01, 3, 1'b1, 2'b00, 1'b1);
    tick(); check("hd_v2", 2'b01, 5, 1'b1, 2'b01, 1'b1);
    req = 2'b00;
    tick(); check("hd_idle", 2'b00, 5, 1'b0, 2'b00, 1'b0);
`endif

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
